// File: rtl/goofy_alu_sequencer_if.sv
// Request/response handshake bundle for the ALU sequencer.
// master = instruction decode side, slave = sequencer side.
interface goofy_alu_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_ov;
   logic        rsp_eq;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_ov, rsp_eq, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_ov, rsp_eq, rsp_err
   );
endinterface

// File: rtl/goofy_alu_sequencer.sv
// Command front end for the 8-bit ALU: one op at a time, fixed
// strobe schedule, 16-bit add/sub as two chained byte passes.
module goofy_alu_sequencer (
   input  logic                 clk,
   input  logic                 res,
   goofy_alu_sequencer_if.slave bus,
   output logic                 alu0w,
   output logic                 alu1w,
   output logic [7:0]           alu0d,
   output logic [7:0]           alu1d,
   output logic                 alu_add,
   output logic                 alu_add_ov,
   output logic                 alu_sub,
   output logic                 alu_sub_ov,
   output logic                 alu_and,
   output logic                 alu_or,
   output logic                 alu_not,
   output logic                 alu_cmp,
   output logic                 alu_hlt,
   output logic                 alu_flag_res,
   input  logic [7:0]           alu_out,
   input  logic                 alu_flag_ov_o,
   input  logic                 alu_flag_eq_o,
   input  logic                 alu_flag_hlt_o
);

   localparam logic [3:0] OP_ADD8  = 4'd0;
   localparam logic [3:0] OP_ADD16 = 4'd1;
   localparam logic [3:0] OP_SUB8  = 4'd2;
   localparam logic [3:0] OP_SUB16 = 4'd3;
   localparam logic [3:0] OP_AND8  = 4'd4;
   localparam logic [3:0] OP_OR8   = 4'd5;
   localparam logic [3:0] OP_NOT8  = 4'd6;
   localparam logic [3:0] OP_CMP8  = 4'd7;
   localparam logic [3:0] OP_HLT   = 4'd8;
   localparam logic [3:0] OP_FRES  = 4'd9;

   localparam int SB_ADD    = 0;
   localparam int SB_ADD_OV = 1;
   localparam int SB_SUB    = 2;
   localparam int SB_SUB_OV = 3;
   localparam int SB_AND    = 4;
   localparam int SB_OR     = 5;
   localparam int SB_NOT    = 6;
   localparam int SB_CMP    = 7;
   localparam int SB_HLT    = 8;
   localparam int SB_FRES   = 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_LD_LO,
      S_EX_LO,
      S_LD_HI,
      S_EX_HI,
      S_RESP
   } state_t;

   state_t      r_state;
   logic [3:0]  r_op;
   logic [15:0] r_a;
   logic [15:0] r_b;
   logic [7:0]  r_lo;
   logic        r_ov_lo;

   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_data;
   logic        r_rsp_ov;
   logic        r_rsp_eq;
   logic        r_rsp_err;

   logic        r_alu0w;
   logic        r_alu1w;
   logic [7:0]  r_alu0d;
   logic [7:0]  r_alu1d;
   logic [9:0]  r_stb;

   logic        w_reject;
   logic        w_op16;
   logic        w_byte_data;
   logic [9:0]  w_hi_stb;

   // First-pass op strobe for a given opcode.
   function automatic logic [9:0] f_lo_stb(input logic [3:0] op);
      logic [9:0] s;
      s = '0;
      unique case (op)
         OP_ADD8,
         OP_ADD16: s[SB_ADD] = 1'b1;
         OP_SUB8,
         OP_SUB16: s[SB_SUB] = 1'b1;
         OP_AND8:  s[SB_AND] = 1'b1;
         OP_OR8:   s[SB_OR]  = 1'b1;
         OP_NOT8:  s[SB_NOT] = 1'b1;
         OP_CMP8:  s[SB_CMP] = 1'b1;
         OP_HLT:   s[SB_HLT] = 1'b1;
         default:  s = '0;
      endcase
      return s;
   endfunction

   // Accept-time screening: illegal opcodes and anything but
   // FLAGRES while the ALU is halted are answered with an error.
   always_comb begin
      w_reject = (bus.req_op > OP_FRES) ||
                 ((bus.req_op != OP_FRES) && alu_flag_hlt_o);
   end

   // Classify the latched op for width and result format.
   always_comb begin
      w_op16 = (r_op == OP_ADD16) || (r_op == OP_SUB16);
      w_byte_data = 1'b0;
      unique case (r_op)
         OP_ADD8,
         OP_SUB8,
         OP_AND8,
         OP_OR8,
         OP_NOT8: w_byte_data = 1'b1;
         default: w_byte_data = 1'b0;
      endcase
   end

   // High-byte strobe: the carry from the low pass is chosen up
   // front so the ALU result does not move during EX_HI.
   always_comb begin
      w_hi_stb = '0;
      if (r_op == OP_ADD16) begin
         if (r_ov_lo) w_hi_stb[SB_ADD_OV] = 1'b1;
         else         w_hi_stb[SB_ADD]    = 1'b1;
      end else begin
         if (r_ov_lo) w_hi_stb[SB_SUB_OV] = 1'b1;
         else         w_hi_stb[SB_SUB]    = 1'b1;
      end
   end

   // Sequencer FSM; every output is a register set on entry to
   // the state that presents it.
   always_ff @(posedge clk) begin
      if (res) begin
         r_state     <= S_IDLE;
         r_op        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_lo        <= '0;
         r_ov_lo     <= 1'b0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_ov    <= 1'b0;
         r_rsp_eq    <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_alu0w     <= 1'b0;
         r_alu1w     <= 1'b0;
         r_alu0d     <= '0;
         r_alu1d     <= '0;
         r_stb       <= '0;
      end else begin
         r_stb   <= '0;
         r_alu0w <= 1'b0;
         r_alu1w <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_op        <= bus.req_op;
                  r_a         <= bus.req_a;
                  r_b         <= bus.req_b;
                  r_req_ready <= 1'b0;
                  if (w_reject) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_data  <= '0;
                     r_rsp_ov    <= 1'b0;
                     r_rsp_eq    <= 1'b0;
                     r_rsp_err   <= 1'b1;
                  end else if (bus.req_op == OP_HLT) begin
                     r_state <= S_EX_LO;
                     r_stb   <= f_lo_stb(bus.req_op);
                  end else begin
                     r_state        <= S_CLR;
                     r_stb[SB_FRES] <= 1'b1;
                  end
               end
            end
            S_CLR: begin
               if (r_op == OP_FRES) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= '0;
                  r_rsp_ov    <= 1'b0;
                  r_rsp_eq    <= 1'b0;
                  r_rsp_err   <= 1'b0;
               end else begin
                  r_state <= S_LD_LO;
                  r_alu0w <= 1'b1;
                  r_alu1w <= 1'b1;
                  r_alu0d <= r_a[7:0];
                  r_alu1d <= r_b[7:0];
               end
            end
            S_LD_LO: begin
               r_state <= S_EX_LO;
               r_stb   <= f_lo_stb(r_op);
            end
            S_EX_LO: begin
               r_lo    <= alu_out;
               r_ov_lo <= alu_flag_ov_o;
               if (w_op16) begin
                  r_state <= S_LD_HI;
                  r_alu0w <= 1'b1;
                  r_alu1w <= 1'b1;
                  r_alu0d <= r_a[15:8];
                  r_alu1d <= r_b[15:8];
               end else begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= w_byte_data ?
                                 {8'h00, alu_out} : 16'h0000;
                  r_rsp_ov    <= alu_flag_ov_o;
                  r_rsp_eq    <= (r_op == OP_CMP8) &&
                                 alu_flag_eq_o;
                  r_rsp_err   <= 1'b0;
               end
            end
            S_LD_HI: begin
               r_state <= S_EX_HI;
               r_stb   <= w_hi_stb;
            end
            S_EX_HI: begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_data  <= {alu_out, r_lo};
               r_rsp_ov    <= alu_flag_ov_o | r_ov_lo;
               r_rsp_eq    <= 1'b0;
               r_rsp_err   <= 1'b0;
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
                  r_rsp_valid <= 1'b0;
                  r_rsp_data  <= '0;
                  r_rsp_ov    <= 1'b0;
                  r_rsp_eq    <= 1'b0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_req_ready <= 1'b1;
               r_rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
   assign bus.rsp_ov    = r_rsp_ov;
   assign bus.rsp_eq    = r_rsp_eq;
   assign bus.rsp_err   = r_rsp_err;

   assign alu0w        = r_alu0w;
   assign alu1w        = r_alu1w;
   assign alu0d        = r_alu0d;
   assign alu1d        = r_alu1d;
   assign alu_add      = r_stb[SB_ADD];
   assign alu_add_ov   = r_stb[SB_ADD_OV];
   assign alu_sub      = r_stb[SB_SUB];
   assign alu_sub_ov   = r_stb[SB_SUB_OV];
   assign alu_and      = r_stb[SB_AND];
   assign alu_or       = r_stb[SB_OR];
   assign alu_not      = r_stb[SB_NOT];
   assign alu_cmp      = r_stb[SB_CMP];
   assign alu_hlt      = r_stb[SB_HLT];
   assign alu_flag_res = r_stb[SB_FRES];

endmodule
